// File: rtl/dnn_pkg.sv
// Shared constants and read-FSM encoding for the MFCC-to-DNN ping-pong context buffer.
// One context window is INFRAME frames of IDIM signed coefficients, stored frame-major.
package dnn_pkg;

  localparam int OBIT    = 13;
  localparam int IDIM    = 26;
  localparam int INFRAME = 5;
  localparam int NVEC    = IDIM * INFRAME;
  localparam int AW      = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  typedef logic signed [OBIT-1:0] coef_t;

  // Window-relative write address: counts 0..NVEC-1 and wraps.
  function automatic logic [AW-1:0] next_wr_addr(input logic [AW-1:0] addr);
    return (addr == AW'(NVEC - 1)) ? '0 : addr + 1'b1;
  endfunction

endpackage

// File: rtl/dnn_dpram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// Bank select is the address MSB, so both ping-pong banks live in one array.
module dnn_dpram #(
  parameter int DW  = 13,
  parameter int RAW = 9
) (
  input  logic           clk,
  input  logic           we,
  input  logic [RAW-1:0] waddr,
  input  logic [DW-1:0]  wdata,
  input  logic           re,
  input  logic [RAW-1:0] raddr,
  output logic [DW-1:0]  rdata
);

  logic [DW-1:0] mem [2**RAW];

  // NOTE: no reset on the array or the read register, so this maps onto a
  // block RAM; the consumer-visible output is masked in the parent instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dnn_frame_buffer.sv
// Ping-pong context buffer: fills one bank from the normalizer stream while the
// DNN layer reads the other, dropping whole windows when both banks are held.
module dnn_frame_buffer
  import dnn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dv_i,
  input  logic signed [OBIT-1:0] vec_i,
  output logic                   start_o,
  output logic                   busy_o,
  input  logic [AW-1:0]          rd_addr_i,
  output logic signed [OBIT-1:0] rd_data_o,
  input  logic                   done_i,
  output logic                   ovf_o
);

  logic [AW-1:0]   wr_addr;
  logic            wr_bank;
  logic            rd_bank;
  logic [1:0]      full;
  logic [1:0]      full_nxt;
  logic            win_acc;
  logic [0:0]      state;
  logic            rd_valid;
  logic [OBIT-1:0] ram_q;

  logic wr_first;
  logic wr_last;
  logic accept;
  logic wr_en;
  logic wr_win_done;
  logic rd_release;
  logic rd_en;

  // Accept/drop is latched once per window at its first sample so a bank
  // freed mid-window never receives a partial window.
  assign wr_first    = (wr_addr == '0);
  assign wr_last     = (wr_addr == AW'(NVEC - 1));
  assign accept      = wr_first ? ~full[wr_bank] : win_acc;
  assign wr_en       = dv_i & accept;
  assign wr_win_done = dv_i & wr_last & accept;
  assign rd_release  = (state == ST_READ) & done_i;
  assign rd_en       = (state == ST_READ);

  // NOTE: combinational blocks use blocking assignments and start from a full
  // default so no path leaves full_nxt unassigned (which would infer a latch).
  always_comb begin
    full_nxt = full;
    if (rd_release)  full_nxt[rd_bank] = 1'b0;
    if (wr_win_done) full_nxt[wr_bank] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr <= '0;
      wr_bank <= 1'b0;
      win_acc <= 1'b0;
      full    <= '0;
      ovf_o   <= 1'b0;
    end else begin
      full <= full_nxt;
      if (dv_i) begin
        wr_addr <= next_wr_addr(wr_addr);
        if (wr_first)    win_acc <= ~full[wr_bank];
        if (!accept)     ovf_o   <= 1'b1;
        if (wr_win_done) wr_bank <= ~wr_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      start_o  <= 1'b0;
      busy_o   <= 1'b0;
      rd_bank  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      start_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (full[rd_bank]) begin
            state   <= ST_READ;
            start_o <= 1'b1;
            busy_o  <= 1'b1;
          end
        end
        ST_READ: begin
          rd_valid <= 1'b1;
          if (done_i) begin
            state   <= ST_IDLE;
            busy_o  <= 1'b0;
            rd_bank <= ~rd_bank;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dnn_dpram #(
    .DW  (OBIT),
    .RAW (AW + 1)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({wr_bank, wr_addr}),
    .wdata (vec_i),
    .re    (rd_en),
    .raddr ({rd_bank, rd_addr_i}),
    .rdata (ram_q)
  );

  // The RAM read register is not reset; hold the output at zero until the
  // first read after reset has actually loaded it.
  assign rd_data_o = rd_valid ? $signed(ram_q) : '0;

endmodule

// File: doc/dnn_frame_buffer.md
Name: dnn_frame_buffer

Overview:
Ping-pong context buffer between the MFCC normalizer and the first DNN layer. It captures the normalizer's serial stream of INFRAME x IDIM signed normalized coefficients (one complete context window) into one bank. It then hands that bank to the DNN layer through a start/done handshake with random-access reads, while the other bank fills. Any context window arriving while both banks are occupied is dropped whole and flagged.

Parameters:
OBIT, 13, width of each signed normalized coefficient (matches normalizer output)
IDIM, 26, coefficients per frame
INFRAME, 5, frames per context window
NVEC, IDIM*INFRAME (130), coefficients per window
AW, 8, read/write address width; must satisfy 2^AW >= NVEC

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
dv_i  in  1  input coefficient valid, one coefficient per cycle while high
vec_i  in  OBIT  signed normalized coefficient, frame-major, dim-minor order
start_o  out  1  one-cycle pulse: a full bank is ready for the consumer
busy_o  out  1  high from the start_o cycle until done_i is accepted
rd_addr_i  in  AW  consumer read address, 0..NVEC-1, frame*IDIM+dim
rd_data_o  out  OBIT  signed coefficient at rd_addr_i of the current read bank
done_i  in  1  consumer finished with the current bank; releases it
ovf_o  out  1  sticky: at least one window was dropped; cleared only by rst

Behaviour:
- Reset: start_o=0, busy_o=0, rd_data_o=0, ovf_o=0, wr_addr=0, wr_bank=0, rd_bank=0, full[1:0]=0, read FSM=IDLE. RAM contents are not cleared. Reset mid-fill or mid-read abandons everything, including partial windows.
- Write side, on each edge with dv_i=1:
  - If full[wr_bank]=0, write vec_i to RAM address {wr_bank, wr_addr}. Otherwise discard and set ovf_o=1.
  - wr_addr increments; at NVEC-1 it wraps to 0.
  - At the wrap: if the window was accepted, set full[wr_bank]=1 and toggle wr_bank. If it was discarded, wr_bank is unchanged.
  - Accept/drop is decided per window by full[wr_bank] at wr_addr=0. A bank freed mid-window does not take a partial window: the rest of that window stays dropped.
- dv_i gaps inside a window are allowed; wr_addr simply holds. There is no separate frame-sync input; alignment comes from reset and exact NVEC counting.
- Read FSM:
  - IDLE: when full[rd_bank]=1, the next edge moves to READ, with start_o=1 for exactly that cycle and busy_o=1.
  - READ: rd_data_o <= RAM[{rd_bank, rd_addr_i}] on every edge, so read latency is 1 cycle.
  - READ with done_i=1: clear full[rd_bank], toggle rd_bank, busy_o=0, return to IDLE. If the other bank is already full, start_o pulses again no earlier than the following edge (at least 1 idle cycle).
- done_i in IDLE is ignored. rd_addr_i >= NVEC in READ gives undefined data and no error.
- Simultaneous events: done_i release and write-side window completion in the same cycle both take effect. A bank released at edge E is writable for a window starting after E.
- Throughput: the consumer may take arbitrarily long. With one window of slack, no drop occurs if done_i arrives before the next-but-one window starts.

Decomposition:
- Shared package (dnn_pkg): OBIT, IDIM, INFRAME, NVEC, AW, and the read FSM state encoding (IDLE, READ).
- One sub-module: dnn_dpram. Simple dual-port RAM, depth 2^(AW+1), width OBIT, one write port, one registered read port, no reset on data. Infers block RAM.

Test Plan:
- Single window: 130 consecutive dv_i with vec_i=addr-64. Required: start_o pulses exactly 1 cycle after the last write edge. Reading addr 0, 65, 129 returns -64, 1, 65 one cycle later. ovf_o=0.
- Ping-pong: second window vec_i=-addr streamed during the READ of window 1, then done_i. Required: start_o re-pulses at least 1 cycle after done_i. Addr 129 reads -129 from bank 1.
- Overflow: three windows with no done_i. Required: first two accepted, ovf_o=1 from the first write cycle of window 3. After done_i twice, bank contents match windows 1 and 2, not 3.
- Mid-window release: both banks full, window 4 starts, done_i at its write index 50. Required: window 4 is still fully dropped. Window 5 is accepted into the freed bank.
- Gapped input: dv_i toggling 1/0 across one window. Required: identical contents to a contiguous fill. start_o comes 1 cycle after the 130th valid.
- Reset mid-read at busy_o=1: assert rst for 1 cycle. Required: all outputs 0, and no start_o until a fresh 130-sample window completes.
